tqvp_nkanderson_wdt_win: RTL

//  Two-stage windowed watchdog peripheral for the TinyQV full-peripheral slot. It has a programmable

---
 rtl/tqvp_nkanderson_wdt_pkg.sv | 41 ++++
 rtl/tqvp_nkanderson_wdt_prescaler.sv | 25 ++
 rtl/tqvp_nkanderson_wdt_win.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/tqvp_nkanderson_wdt_pkg.sv
// Shared definitions for the windowed watchdog: register map, FSM states,
// CTRL/STATUS bit positions and the byte-lane write merge helper.
package tqvp_nkanderson_wdt_pkg;

  localparam logic [5:0] A_CTRL    = 6'h00;
  localparam logic [5:0] A_TIMEOUT = 6'h04;
  localparam logic [5:0] A_GRACE   = 6'h08;
  localparam logic [5:0] A_KICK    = 6'h0C;
  localparam logic [5:0] A_COUNT   = 6'h10;
  localparam logic [5:0] A_STATUS  = 6'h14;
  localparam logic [5:0] A_WINDOW  = 6'h18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    BARK = 2'd2,
    BITE = 2'd3
  } wdt_state_e;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_LOCK     = 1;
  localparam int CTRL_BITE_IRQ = 2;
  localparam int CTRL_EXT_KICK = 3;

  localparam int ST_BARK    = 0;
  localparam int ST_BITE    = 1;
  localparam int ST_BADKICK = 2;

  // Byte lane 0 takes any write, lane 1 half/word, lanes 2-3 word only.
  function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [1:0]  wr_n);
    logic [31:0] r;
    r = old;
    if (wr_n != 2'b11) r[7:0] = wd[7:0];
    if (wr_n == 2'b01 || wr_n == 2'b10) r[15:8] = wd[15:8];
    if (wr_n == 2'b10) r[31:16] = wd[31:16];
    return r;
  endfunction

endpackage

// File: rtl/tqvp_nkanderson_wdt_prescaler.sv
// Free-running 16-bit prescaler. Ticks when the low PS bits are all ones,
// so PS=0 ticks every enabled cycle and PS=n ticks every 2^n cycles.
module tqvp_nkanderson_wdt_prescaler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic [3:0] i_ps,
  output logic       o_tick
);

  logic [15:0] r_cnt;
  logic [15:0] w_mask;

  assign w_mask = (16'h0001 << i_ps) - 16'h0001;
  assign o_tick = i_en && ((r_cnt & w_mask) == w_mask);

  // Count while enabled; a clear restarts the tick phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 16'h0001;
  end

endmodule

// File: rtl/tqvp_nkanderson_wdt_win.sv
// Two-stage windowed watchdog for the TinyQV peripheral slot.
// First expiry raises bark (interrupt), second raises a timed bite pulse.
// Optional feature: define WDT_WINDOW_EN to add the WINDOW register and
// the too-early-kick check.
module tqvp_nkanderson_wdt_win
  import tqvp_nkanderson_wdt_pkg::*;
#(
  parameter int          CNT_W      = 24,
  parameter logic [31:0] KICK_KEY   = 32'h5A5A_A5A5,
  parameter int          BITE_PULSE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int BW = (BITE_PULSE > 1) ? $clog2(BITE_PULSE) : 1;

  wdt_state_e       r_state, w_state_nxt;
  logic [7:0]       r_ctrl;
  logic [CNT_W-1:0] r_timeout, r_grace, r_count;
  logic [2:0]       r_status;
  logic             r_bite_on;
  logic [BW-1:0]    r_bite_cnt;
  logic             r_ext_q;

  logic        w_wr, w_tick;
  logic        w_ctrl_we, w_to_we, w_gr_we, w_st_we;
  logic [31:0] w_ctrl_m, w_to_m, w_gr_m;
  logic        w_kick_wr, w_key_ok, w_sw_kick, w_ext_kick, w_kick, w_too_early;
  logic        w_ld_to, w_ld_gr, w_dec, w_psc_clr;
  logic        w_set_bark, w_set_bite, w_bite_go, w_win_bad;
  logic [2:0]  w_st_set, w_st_clr;
  logic        w_unused;

  // ---------------- bus decode ----------------
  assign w_wr      = (data_write_n != 2'b11);
  assign w_ctrl_we = w_wr && (address == A_CTRL)    && !r_ctrl[CTRL_LOCK];
  assign w_to_we   = w_wr && (address == A_TIMEOUT) && !r_ctrl[CTRL_LOCK];
  assign w_gr_we   = w_wr && (address == A_GRACE)   && !r_ctrl[CTRL_LOCK];
  assign w_st_we   = w_wr && (address == A_STATUS);

  assign w_ctrl_m = lane_merge({24'h0, r_ctrl}, data_in, data_write_n);
  assign w_to_m   = lane_merge(32'(r_timeout), data_in, data_write_n);
  assign w_gr_m   = lane_merge(32'(r_grace), data_in, data_write_n);

  // Only a full-word write of the key counts; anything else is a bad kick.
  assign w_kick_wr  = w_wr && (address == A_KICK);
  assign w_key_ok   = (data_write_n == 2'b10) && (data_in == KICK_KEY);
  assign w_sw_kick  = w_kick_wr && w_key_ok;
  assign w_ext_kick = r_ctrl[CTRL_EXT_KICK] && ui_in[5] && !r_ext_q;
  assign w_kick     = w_sw_kick || w_ext_kick;

`ifdef WDT_WINDOW_EN
  logic [CNT_W-1:0] r_window;
  logic             w_win_we;
  logic [31:0]      w_win_m;

  assign w_win_we    = w_wr && (address == A_WINDOW) && !r_ctrl[CTRL_LOCK];
  assign w_win_m     = lane_merge(32'(r_window), data_in, data_write_n);
  assign w_too_early = (r_window != '0) && (r_count > r_window);

  // Window register; zero disables the early-kick check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_window <= '0;
    else if (w_win_we) r_window <= w_win_m[CNT_W-1:0];
  end
`else
  logic [31:0] w_win_m;
  assign w_win_m     = 32'h0;
  assign w_too_early = 1'b0;
`endif

  // Configuration registers; lock freezes them until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl    <= '0;
      r_timeout <= '0;
      r_grace   <= '0;
    end else begin
      if (w_ctrl_we) r_ctrl    <= w_ctrl_m[7:0];
      if (w_to_we)   r_timeout <= w_to_m[CNT_W-1:0];
      if (w_gr_we)   r_grace   <= w_gr_m[CNT_W-1:0];
    end
  end

  // Previous level of the (already synchronised) external kick pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ext_q <= 1'b0;
    else        r_ext_q <= ui_in[5];
  end

  // ---------------- prescaler ----------------
  tqvp_nkanderson_wdt_prescaler u_psc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_state != IDLE),
    .i_clr  (w_psc_clr),
    .i_ps   (r_ctrl[7:4]),
    .o_tick (w_tick)
  );

  // ---------------- FSM ----------------
  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and datapath strobes; disable wins, then kick beats expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_to     = 1'b0;
    w_ld_gr     = 1'b0;
    w_dec       = 1'b0;
    w_psc_clr   = 1'b0;
    w_set_bark  = 1'b0;
    w_set_bite  = 1'b0;
    w_bite_go   = 1'b0;
    w_win_bad   = 1'b0;
    if (!r_ctrl[CTRL_EN]) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = RUN;
          w_ld_to     = 1'b1;
          w_psc_clr   = 1'b1;
        end
        RUN: begin
          if (w_kick && w_too_early) begin
            w_state_nxt = BITE;
            w_win_bad   = 1'b1;
            w_set_bite  = 1'b1;
            w_bite_go   = 1'b1;
            w_ld_to     = 1'b1;
          end else if (w_kick) begin
            w_ld_to   = 1'b1;
            w_psc_clr = 1'b1;
          end else if (w_tick) begin
            if (r_count == '0) begin
              w_state_nxt = BARK;
              w_set_bark  = 1'b1;
              w_ld_gr     = 1'b1;
            end else begin
              w_dec = 1'b1;
            end
          end
        end
        BARK: begin
          if (w_kick) begin
            w_state_nxt = RUN;
            w_ld_to     = 1'b1;
            w_psc_clr   = 1'b1;
          end else if (w_tick) begin
            if (r_count == '0) begin
              w_state_nxt = BITE;
              w_set_bite  = 1'b1;
              w_bite_go   = 1'b1;
              w_ld_to     = 1'b1;
            end else begin
              w_dec = 1'b1;
            end
          end
        end
        BITE: begin
          if (!r_bite_on || (r_bite_cnt == '0)) w_state_nxt = RUN;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Stage counter: reload on stage entry/kick, saturating decrement on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_count <= '0;
    else if (w_ld_to) r_count <= r_timeout;
    else if (w_ld_gr) r_count <= r_grace;
    else if (w_dec)   r_count <= r_count - CNT_W'(1);
  end

  // Bite pulse timer; runs to completion even if the FSM leaves BITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bite_on  <= 1'b0;
      r_bite_cnt <= '0;
    end else if (w_bite_go) begin
      r_bite_on  <= 1'b1;
      r_bite_cnt <= BW'(BITE_PULSE - 1);
    end else if (r_bite_on) begin
      if (r_bite_cnt == '0) r_bite_on  <= 1'b0;
      else                  r_bite_cnt <= r_bite_cnt - BW'(1);
    end
  end

  // STATUS W1C; a hardware set on the same cycle wins over the clear.
  assign w_st_set = {w_win_bad || (w_kick_wr && !w_key_ok), w_set_bite, w_set_bark};
  assign w_st_clr = w_st_we ? data_in[2:0] : 3'b000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_status <= '0;
    else        r_status <= w_st_set | (r_status & ~w_st_clr);
  end

  // ---------------- outputs ----------------
  // Side-effect-free read mux.
  always_comb begin
    data_out = 32'h0;
    case (address)
      A_CTRL:    data_out = {24'h0, r_ctrl};
      A_TIMEOUT: data_out = 32'(r_timeout);
      A_GRACE:   data_out = 32'(r_grace);
      A_COUNT:   data_out = 32'(r_count);
      A_STATUS:  data_out = {29'h0, r_status};
`ifdef WDT_WINDOW_EN
      A_WINDOW:  data_out = 32'(r_window);
`endif
      default:   data_out = 32'h0;
    endcase
  end

  assign data_ready     = 1'b1;
  assign uo_out         = {4'b0000, (r_state != IDLE), r_status[ST_BARK], r_bite_on, 1'b0};
  assign user_interrupt = r_status[ST_BARK] || r_status[ST_BADKICK] ||
                          (r_ctrl[CTRL_BITE_IRQ] && r_status[ST_BITE]);

  assign w_unused = ^{data_read_n, ui_in, w_ctrl_m, w_to_m, w_gr_m, w_win_m};

endmodule
